io_bridge: RTL

IO_BRIDGE -- requirements
Module: io_bridge

---
 rtl/io_bridge.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/io_bridge.sv
// CPU-to-UART I/O bridge: TX byte FIFO, RX read port, cycle counter and a stop sequence FSM.
// Optional macro IO_BRIDGE_CYCLE_SNAPSHOT_EN adds a coherent 32-bit counter snapshot for byte reads.
module io_bridge #(
  parameter int FIFO_WIDTH  = 3,
  parameter int FULL_MARGIN = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic        io_sel,
  output logic [7:0]  io_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_pop,
  output logic        program_done,
  output logic [1:0]  dbg_state
);

  // tx_valid/tx_ready: a byte transfers on every rising edge where both are high;
  // tx_data is stable whenever tx_valid is high and only advances after a transfer.

  localparam int DEPTH = 1 << FIFO_WIDTH;
  localparam logic [FIFO_WIDTH:0]   DEPTH_C  = (FIFO_WIDTH+1)'(DEPTH);
  localparam logic [FIFO_WIDTH:0]   FULL_LVL = (FIFO_WIDTH+1)'(DEPTH - FULL_MARGIN);
  localparam logic [FIFO_WIDTH:0]   CNT_ONE  = (FIFO_WIDTH+1)'(1);
  localparam logic [FIFO_WIDTH-1:0] PTR_ONE  = FIFO_WIDTH'(1);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_TERM  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [7:0]            fifo_mem [DEPTH];
  logic [FIFO_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_WIDTH:0]   count_q, count_d;
  logic                  full_q, full_d;
  logic [1:0]            state_q, state_d;
  logic                  done_q, done_d;
  logic [31:0]           cnt_q, cnt_d;
  logic [7:0]            io_din_q, io_din_d;
  logic                  rx_pop_q, rx_pop_d;

  logic        acc, wr_acc, rd_acc;
  logic [15:0] lo_addr;
  logic        hit_data, hit_cnt, hit_stop;
  logic        fifo_empty, fifo_full;
  logic        push, pop;
  logic [31:0] cnt_view;
  logic [7:0]  rd_byte;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^mem_a[31:18];

  // Address decode: only mem_a[17:0] matter; the window is 0x3xxxx.
  assign io_sel   = (mem_a[17:16] == 2'b11);
  assign acc      = rdy_in & io_sel;
  assign wr_acc   = acc & mem_wr;
  assign rd_acc   = acc & ~mem_wr;
  assign lo_addr  = mem_a[15:0];
  assign hit_data = (lo_addr == 16'h0000);
  assign hit_cnt  = (lo_addr[15:2] == 14'h0001);
  assign hit_stop = (lo_addr == 16'h0004);

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DEPTH_C);

  // Zero bytes are reserved as the terminator, so they never enter the FIFO.
  assign push = wr_acc & hit_data & (mem_dout != 8'h00) & (state_q == ST_RUN) & ~fifo_full;
  assign pop  = ~fifo_empty & tx_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    full_d = (count_d >= FULL_LVL);
  end

  always_ff @(posedge clk_in) begin
    if (push) fifo_mem[wr_ptr_q] <= mem_dout;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (wr_acc && hit_stop) state_d = ST_DRAIN;
      ST_DRAIN: if (fifo_empty) state_d = ST_TERM;
      ST_TERM:  if (tx_ready) state_d = ST_DONE;
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_RUN;
    endcase
    done_d = done_q | (state_d == ST_DONE);
  end

  assign cnt_d = cnt_q + 32'd1;

`ifdef IO_BRIDGE_CYCLE_SNAPSHOT_EN
  logic [31:0] snap_q, snap_d;

  // Byte 0 read captures the whole counter so bytes 1..3 stay coherent with it.
  assign snap_d   = (rd_acc && hit_cnt && (lo_addr[1:0] == 2'd0)) ? cnt_q : snap_q;
  assign cnt_view = (lo_addr[1:0] == 2'd0) ? cnt_q : snap_q;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) snap_q <= '0;
    else         snap_q <= snap_d;
  end
`else
  assign cnt_view = cnt_q;
`endif

  always_comb begin
    rd_byte = 8'h00;
    if (hit_data) begin
      rd_byte = rx_valid ? rx_data : 8'h00;
    end else if (hit_cnt) begin
      case (lo_addr[1:0])
        2'd0:    rd_byte = cnt_view[7:0];
        2'd1:    rd_byte = cnt_view[15:8];
        2'd2:    rd_byte = cnt_view[23:16];
        default: rd_byte = cnt_view[31:24];
      endcase
    end
    io_din_d = rd_acc ? rd_byte : io_din_q;
    rx_pop_d = rd_acc & hit_data & rx_valid;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      state_q  <= ST_RUN;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      io_din_q <= 8'h00;
      rx_pop_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      state_q  <= state_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      io_din_q <= io_din_d;
      rx_pop_q <= rx_pop_d;
    end
  end

  // The terminator is sent from TERM; the FIFO is necessarily empty by then.
  assign tx_valid       = ~fifo_empty | (state_q == ST_TERM);
  assign tx_data        = (state_q == ST_TERM) ? 8'h00 : fifo_mem[rd_ptr_q];
  assign io_din         = io_din_q;
  assign io_buffer_full = full_q;
  assign rx_pop         = rx_pop_q;
  assign program_done   = done_q;
  assign dbg_state      = state_q;

endmodule
